// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the trigger-mode reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_ADC_DELAY = 3'd2,
    S_RUN       = 3'd3,
    S_RAMP_DOWN = 3'd4,
    S_FAULT     = 3'd5
  } seq_state_t;

  localparam int CLK_FREQ_HZ                 = 125_000_000;
  localparam int DEF_RAMP_TIMEOUT_CYCLES     = CLK_FREQ_HZ;       // 1 s
  localparam int DEF_WATCHDOG_TIMEOUT_CYCLES = CLK_FREQ_HZ / 10;  // 100 ms
  localparam int DEF_ADC_DELAY_CYCLES        = 125;

  // Counter width wide enough for the largest limit plus saturation headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    if (m < 1) m = 1;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating cycle counter with a terminal-count flag.
// tc is high once LIMIT-1 cycles have been counted since the last clear, so
// a state that exits on tc lasts exactly LIMIT cycles. LIMIT=0 acts as 1.
module seq_timeout_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int           LIM_EFF = (LIMIT < 1) ? 1 : LIMIT;
  localparam logic [W-1:0] SAT     = W'(LIM_EFF);
  localparam logic [W-1:0] TERM    = W'(LIM_EFF - 1);

  logic [W-1:0] count;

  // Count enabled cycles, stopping at the limit so the value never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && count != SAT)
      count <= count + 1'b1;
  end

  assign tc = (count >= TERM);

endmodule

// File: rtl/reset_sequencer.sv
// Power-up / shutdown sequencer for the DAC and ADC/RAM-writer chains.
// Optional macro RESET_SEQ_RUN_COUNTER_EN adds the run_cycles output.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int RAMP_TIMEOUT_CYCLES     = DEF_RAMP_TIMEOUT_CYCLES,
  parameter int WATCHDOG_TIMEOUT_CYCLES = DEF_WATCHDOG_TIMEOUT_CYCLES,
  parameter int ADC_DELAY_CYCLES        = DEF_ADC_DELAY_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] cfg_ramp_en,
  input  logic       cfg_watchdog_en,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_clear,
  input  logic       watchdog_in,
  input  logic [1:0] ramp_up_done,
  input  logic [1:0] ramp_down_done,
  output logic       dac_aresetn,
  output logic       adc_aresetn,
  output logic [1:0] ramping_enable,
  output logic [1:0] start_ramp_down,
  output logic       fault,
  output logic       wd_expired,
  output logic [2:0] seq_state,
  output logic       busy
`ifdef RESET_SEQ_RUN_COUNTER_EN
  ,
  output logic [31:0] run_cycles
`endif
);

  localparam int CNT_W = cnt_width(RAMP_TIMEOUT_CYCLES, WATCHDOG_TIMEOUT_CYCLES, ADC_DELAY_CYCLES);

  seq_state_t state, next_state;
  logic [1:0] en, en_next;
  logic       wd_exp_next;
  logic [2:0] wd_sync;
  logic       wd_edge, wd_active, wd_tc, wd_fire;
  logic       ramp_tc, adc_tc, up_done, down_done, chain_on;

  assign up_done   = (ramp_up_done & en) == en;
  assign down_done = (ramp_down_done & en) == en;
  assign wd_edge   = wd_sync[2] ^ wd_sync[1];
  assign wd_active = cfg_watchdog_en && (state inside {S_RAMP_UP, S_ADC_DELAY, S_RUN});
  assign wd_fire   = wd_active && wd_tc && !wd_edge;
  assign chain_on  = next_state inside {S_RAMP_UP, S_ADC_DELAY, S_RUN, S_RAMP_DOWN};
  assign seq_state = state;

  // Ramp timer is shared by RAMP_UP and RAMP_DOWN; restarts on every state change.
  seq_timeout_counter #(.W(CNT_W), .LIMIT(RAMP_TIMEOUT_CYCLES)) u_ramp_tmr (
    .clk(clk), .rst(rst), .clear(next_state != state),
    .enable(state == S_RAMP_UP || state == S_RAMP_DOWN), .tc(ramp_tc));

  seq_timeout_counter #(.W(CNT_W), .LIMIT(ADC_DELAY_CYCLES)) u_adc_tmr (
    .clk(clk), .rst(rst), .clear(next_state != state),
    .enable(state == S_ADC_DELAY), .tc(adc_tc));

  // Watchdog timer spans RAMP_UP..RUN; any heartbeat edge restarts it.
  seq_timeout_counter #(.W(CNT_W), .LIMIT(WATCHDOG_TIMEOUT_CYCLES)) u_wd_tmr (
    .clk(clk), .rst(rst), .clear(!wd_active || wd_edge),
    .enable(wd_active), .tc(wd_tc));

  // Bring the asynchronous heartbeat into the clock domain; bit 2 is the edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) wd_sync <= '0;
    else     wd_sync <= {wd_sync[1:0], watchdog_in};
  end

  // Next-state, latched enables and sticky watchdog cause.
  always_comb begin
    next_state  = state;
    en_next     = en;
    wd_exp_next = wd_expired;
    case (state)
      S_IDLE:
        if (start && !stop) begin
          en_next    = cfg_ramp_en;
          next_state = (cfg_ramp_en != 2'b00) ? S_RAMP_UP : S_ADC_DELAY;
        end
      S_RAMP_UP:
        if (stop)         next_state = S_RAMP_DOWN;
        else if (wd_fire) begin
          next_state  = S_RAMP_DOWN;
          wd_exp_next = 1'b1;
        end
        else if (up_done) next_state = S_ADC_DELAY;
        else if (ramp_tc) next_state = S_FAULT;
      S_ADC_DELAY:
        if (stop)         next_state = S_RAMP_DOWN;
        else if (wd_fire) begin
          next_state  = (en != 2'b00) ? S_RAMP_DOWN : S_FAULT;
          wd_exp_next = 1'b1;
        end
        else if (adc_tc)  next_state = S_RUN;
      S_RUN:
        if (stop)         next_state = (en != 2'b00) ? S_RAMP_DOWN : S_IDLE;
        else if (wd_fire) begin
          next_state  = (en != 2'b00) ? S_RAMP_DOWN : S_FAULT;
          wd_exp_next = 1'b1;
        end
      S_RAMP_DOWN:
        if (down_done)    next_state = wd_expired ? S_FAULT : S_IDLE;
        else if (ramp_tc) next_state = S_FAULT;
      S_FAULT:
        if (fault_clear) begin
          next_state  = S_IDLE;
          wd_exp_next = 1'b0;
        end
      default: next_state = S_IDLE;
    endcase
  end

  // State and all outputs move together, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      en              <= '0;
      wd_expired      <= 1'b0;
      dac_aresetn     <= 1'b0;
      adc_aresetn     <= 1'b0;
      ramping_enable  <= '0;
      start_ramp_down <= '0;
      fault           <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= next_state;
      en              <= en_next;
      wd_expired      <= wd_exp_next;
      dac_aresetn     <= chain_on;
      adc_aresetn     <= (next_state == S_RUN);
      ramping_enable  <= chain_on ? en_next : 2'b00;
      start_ramp_down <= (next_state == S_RAMP_DOWN) ? en_next : 2'b00;
      fault           <= (next_state == S_FAULT);
      busy            <= (next_state != S_IDLE);
    end
  end

`ifdef RESET_SEQ_RUN_COUNTER_EN
  // Length of the most recent RUN interval; held after leaving RUN.
  always_ff @(posedge clk) begin
    if (rst)
      run_cycles <= '0;
    else if (next_state == S_RUN && state != S_RUN)
      run_cycles <= '0;
    else if (state == S_RUN && run_cycles != 32'hFFFF_FFFF)
      run_cycles <= run_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: each stimulus step pushes the state
// transitions it should cause (cycle, state, full output vector); a monitor
// pops one entry per observed state change and compares.
module tb_reset_sequencer;

  localparam int RAMP_TO = 100;
  localparam int WD_TO   = 50;
  localparam int ADC_DLY = 4;
  // Heartbeat toggle to watchdog restart: two synchroniser flops plus edge detect.
  localparam int WD_LAT  = 3;

  localparam logic [2:0] IDLE = 3'd0, RAMP_UP = 3'd1, ADC_DELAY = 3'd2,
                         RUN = 3'd3, RAMP_DOWN = 3'd4, FAULT = 3'd5;

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] cfg_ramp_en = 2'b00;
  logic       cfg_watchdog_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic       fault_clear = 1'b0, watchdog_in = 1'b0;
  logic [1:0] ramp_up_done = 2'b00, ramp_down_done = 2'b00;
  logic       dac_aresetn, adc_aresetn, fault, wd_expired, busy;
  logic [1:0] ramping_enable, start_ramp_down;
  logic [2:0] seq_state;

  reset_sequencer #(
    .RAMP_TIMEOUT_CYCLES(RAMP_TO), .WATCHDOG_TIMEOUT_CYCLES(WD_TO), .ADC_DELAY_CYCLES(ADC_DLY)
  ) dut (
    .clk(clk), .rst(rst), .cfg_ramp_en(cfg_ramp_en), .cfg_watchdog_en(cfg_watchdog_en),
    .start(start), .stop(stop), .fault_clear(fault_clear), .watchdog_in(watchdog_in),
    .ramp_up_done(ramp_up_done), .ramp_down_done(ramp_down_done),
    .dac_aresetn(dac_aresetn), .adc_aresetn(adc_aresetn), .ramping_enable(ramping_enable),
    .start_ramp_down(start_ramp_down), .fault(fault), .wd_expired(wd_expired),
    .seq_state(seq_state), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] dut_vec;
  assign dut_vec = {seq_state, dac_aresetn, adc_aresetn, ramping_enable,
                    start_ramp_down, fault, wd_expired, busy};

  typedef struct { int at; logic [11:0] v; } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // What the outputs must look like while sitting in a given state.
  function automatic logic [11:0] outs(input logic [2:0] st, input logic [1:0] en, input logic wdx);
    logic dac, adc, flt, bsy;
    logic [1:0] re, srd;
    dac = 1'b0; adc = 1'b0; flt = 1'b0; bsy = (st != IDLE); re = 2'b00; srd = 2'b00;
    case (st)
      RAMP_UP, ADC_DELAY: begin dac = 1'b1; re = en; end
      RUN:                begin dac = 1'b1; adc = 1'b1; re = en; end
      RAMP_DOWN:          begin dac = 1'b1; re = en; srd = en; end
      FAULT:              flt = 1'b1;
      default: ;
    endcase
    return {st, dac, adc, re, srd, flt, wdx, bsy};
  endfunction

  task automatic expect_ev(input int at, input logic [2:0] st, input logic [1:0] en, input logic wdx);
    exp_q.push_back('{at, outs(st, en, wdx)});
  endtask

  // Monitor: every state change must match the next expected transition.
  logic [2:0] prev_st = 3'd0;
  int ev_n = 0;
  always @(negedge clk) begin
    if (seq_state !== prev_st) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_transition", {29'd0, seq_state}, {29'd0, prev_st});
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("ev%0d_outputs", ev_n), {20'd0, dut_vec}, {20'd0, mon_e.v});
        chk($sformatf("ev%0d_cycle", ev_n), cyc, mon_e.at);
      end
      ev_n <= ev_n + 1;
    end
    prev_st <= seq_state;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic pulse_start(input logic [1:0] en);
    cfg_ramp_en = en; start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; step(1); stop = 1'b0;
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1; step(1); fault_clear = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin step(1); n++; end
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int e0, t, p, k;
    logic [1:0] en;

    step(3);
    chk("reset_outputs", {20'd0, dut_vec}, 32'd0);
    rst = 1'b0;
    step(1);

    // Normal start/run/stop with random channel mask and timing.
    for (int it = 0; it < 4; it++) begin
      en = 2'($urandom_range(1, 3));
      e0 = cyc + 1;
      expect_ev(e0, RAMP_UP, en, 1'b0);
      pulse_start(en);
      ramp_up_done = (en == 2'b11) ? 2'b01 : ~en;  // never covers all enabled channels
      step($urandom_range(0, 30));
      t = cyc + 1;
      expect_ev(t, ADC_DELAY, en, 1'b0);
      expect_ev(t + ADC_DLY, RUN, en, 1'b0);
      ramp_up_done = en;
      go_to(t + ADC_DLY + $urandom_range(0, 10));
      t = cyc + 1;
      expect_ev(t, RAMP_DOWN, en, 1'b0);
      pulse_stop();
      ramp_up_done = 2'b00;
      step($urandom_range(0, 20));
      t = cyc + 1;
      expect_ev(t, IDLE, 2'b00, 1'b0);
      ramp_down_done = en;
      step(1);
      ramp_down_done = 2'b00;
      drain(50);
    end

    // Ramp-up timeout, then start/stop ignored in FAULT, then clear.
    en = 2'($urandom_range(1, 3));
    e0 = cyc + 1;
    expect_ev(e0, RAMP_UP, en, 1'b0);
    expect_ev(e0 + RAMP_TO, FAULT, en, 1'b0);
    pulse_start(en);
    go_to(e0 + RAMP_TO - 2);
    chk("no_early_ramp_timeout", {29'd0, seq_state}, {29'd0, RAMP_UP});
    go_to(e0 + RAMP_TO + 1);
    pulse_start(en);
    pulse_stop();
    step(3);
    chk("fault_ignores_start_stop", {29'd0, seq_state}, {29'd0, FAULT});
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    pulse_clear();
    drain(300);

    // Ramp-up done on the very cycle the timeout expires: done wins.
    // Then ramp-down times out into FAULT.
    en = 2'($urandom_range(1, 3));
    e0 = cyc + 1;
    expect_ev(e0, RAMP_UP, en, 1'b0);
    expect_ev(e0 + RAMP_TO, ADC_DELAY, en, 1'b0);
    expect_ev(e0 + RAMP_TO + ADC_DLY, RUN, en, 1'b0);
    pulse_start(en);
    go_to(e0 + RAMP_TO - 1);
    ramp_up_done = en;
    go_to(e0 + RAMP_TO + ADC_DLY + 2);
    ramp_up_done = 2'b00;
    t = cyc + 1;
    expect_ev(t, RAMP_DOWN, en, 1'b0);
    expect_ev(t + RAMP_TO, FAULT, en, 1'b0);
    pulse_stop();
    go_to(t + RAMP_TO + 2);
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    pulse_clear();
    drain(300);

    // Stop during RAMP_UP; stop and start ignored during RAMP_DOWN.
    en = 2'($urandom_range(1, 3));
    expect_ev(cyc + 1, RAMP_UP, en, 1'b0);
    pulse_start(en);
    step($urandom_range(1, 5));
    expect_ev(cyc + 1, RAMP_DOWN, en, 1'b0);
    pulse_stop();
    step(2);
    pulse_stop();
    pulse_start(en);
    step(2);
    chk("stop_ignored_in_ramp_down", {29'd0, seq_state}, {29'd0, RAMP_DOWN});
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    ramp_down_done = en;
    step(1);
    ramp_down_done = 2'b00;
    drain(50);

    // start and stop together in IDLE: stop wins.
    cfg_ramp_en = 2'b11; start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    step(3);
    chk("start_stop_same_cycle", {20'd0, dut_vec}, 32'd0);

    // No channels enabled: skip ramping, stop from RUN goes straight to IDLE.
    e0 = cyc + 1;
    expect_ev(e0, ADC_DELAY, 2'b00, 1'b0);
    expect_ev(e0 + ADC_DLY, RUN, 2'b00, 1'b0);
    pulse_start(2'b00);
    go_to(e0 + ADC_DLY + $urandom_range(0, 5));
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    pulse_stop();
    drain(50);

    // Watchdog: heartbeats keep RUN alive; silence -> RAMP_DOWN, then FAULT.
    cfg_watchdog_en = 1'b1;
    en = 2'($urandom_range(1, 3));
    e0 = cyc + 1;
    expect_ev(e0, RAMP_UP, en, 1'b0);
    expect_ev(e0 + 1, ADC_DELAY, en, 1'b0);
    expect_ev(e0 + 1 + ADC_DLY, RUN, en, 1'b0);
    pulse_start(en);
    ramp_up_done = en;
    k = $urandom_range(3, 5);
    p = e0 + 10;
    for (int i = 0; i < k; i++) begin
      go_to(p);
      watchdog_in = ~watchdog_in;
      if (i < k - 1) p = p + int'($urandom_range(20, 40));
    end
    expect_ev(p + WD_LAT + WD_TO, RAMP_DOWN, en, 1'b1);
    go_to(p + WD_LAT + WD_TO - 1);
    chk("wd_heartbeat_keeps_run", {29'd0, seq_state}, {29'd0, RUN});
    go_to(p + WD_LAT + WD_TO);
    expect_ev(cyc + 1, FAULT, en, 1'b1);
    ramp_down_done = en;
    step(1);
    ramp_down_done = 2'b00;
    ramp_up_done = 2'b00;
    step(2);
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    pulse_clear();
    drain(300);

    // Watchdog with no channels: expiry goes straight to FAULT.
    e0 = cyc + 1;
    expect_ev(e0, ADC_DELAY, 2'b00, 1'b0);
    expect_ev(e0 + ADC_DLY, RUN, 2'b00, 1'b0);
    expect_ev(e0 + WD_TO, FAULT, 2'b00, 1'b1);
    pulse_start(2'b00);
    go_to(e0 + WD_TO + 2);
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    pulse_clear();
    drain(100);
    cfg_watchdog_en = 1'b0;

    // Reset in RAMP_UP aborts immediately with no ramp-down.
    en = 2'($urandom_range(1, 3));
    expect_ev(cyc + 1, RAMP_UP, en, 1'b0);
    pulse_start(en);
    step($urandom_range(2, 10));
    expect_ev(cyc + 1, IDLE, 2'b00, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(3);
    drain(20);
    chk("idle_after_reset", {20'd0, dut_vec}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: reached cycle %0d, expected end before it", cyc);
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences power-up and shutdown of the acquisition/generation chain in trigger mode.
- Start: releases DAC reset, waits for per-channel ramp-up, waits a settle delay, then releases ADC/RAM-writer reset.
- Stop or watchdog expiry: asserts ADC reset, commands ramp-down, waits, then returns to idle.
- Sits between the PS config registers and the reset/ramping outputs feeding fourier_synth, pdm and write_to_ram.

Parameters:
- RAMP_TIMEOUT_CYCLES, 125000000, max cycles allowed in RAMP_UP or RAMP_DOWN (1 s @125 MHz).
- WATCHDOG_TIMEOUT_CYCLES, 12500000, max cycles between watchdog edges (100 ms).
- ADC_DELAY_CYCLES, 125, settle cycles between ramp-up done and ADC release.

Ports:
- clk  in  1  system clock, 125 MHz
- rst  in  1  synchronous, active-high reset
- cfg_ramp_en  in  2  per-channel ramping enable; sampled on accepted start
- cfg_watchdog_en  in  1  enables watchdog supervision
- start  in  1  single-cycle start pulse
- stop  in  1  single-cycle stop pulse
- fault_clear  in  1  single-cycle pulse; leaves FAULT
- watchdog_in  in  1  asynchronous heartbeat; 2-flop synchronised internally
- ramp_up_done  in  2  per-channel level: ramp-up complete
- ramp_down_done  in  2  per-channel level: ramp-down complete
- dac_aresetn  out  1  active-low reset to fourier_synth/pdm
- adc_aresetn  out  1  active-low reset to write_to_ram/ramwriter
- ramping_enable  out  2  latched channel enables
- start_ramp_down  out  2  ramp-down command per channel
- fault  out  1  sticky fault flag
- wd_expired  out  1  sticky: fault was caused by watchdog
- seq_state  out  3  current state encoding
- busy  out  1  high when state != IDLE

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. All outputs 0 on the next edge: dac_aresetn, adc_aresetn, ramping_enable, start_ramp_down, fault, wd_expired, busy; seq_state=IDLE. All counters cleared. Reset mid-operation aborts immediately with no ramp-down.
- All outputs are registered and update on the same edge as the state transition. Input sampled at edge N -> output visible after edge N.
- States and encodings: IDLE=0, RAMP_UP=1, ADC_DELAY=2, RUN=3, RAMP_DOWN=4, FAULT=5.
- IDLE:
  - Both resets asserted.
  - start && !stop: latch en=cfg_ramp_en; dac_aresetn=1; go to RAMP_UP if en!=0, else ADC_DELAY.
  - start && stop in the same cycle: stop wins, stay IDLE.
- RAMP_UP:
  - ramping_enable=en.
  - Exit to ADC_DELAY when (ramp_up_done & en)==en.
  - stop -> RAMP_DOWN.
  - Counter reaches RAMP_TIMEOUT_CYCLES -> FAULT, fault=1.
- ADC_DELAY:
  - Counter from 0; at ADC_DELAY_CYCLES-1 go to RUN and set adc_aresetn=1.
  - ADC_DELAY_CYCLES=0 behaves as 1.
  - stop -> RAMP_DOWN.
- RUN: stop -> RAMP_DOWN if en!=0, else IDLE (dac_aresetn=0).
- RAMP_DOWN:
  - On entry: adc_aresetn=0 and start_ramp_down=en, held until exit.
  - Exit when (ramp_down_done & en)==en, to IDLE (or to FAULT if wd_expired).
  - Timeout -> FAULT.
  - On exit: dac_aresetn=0, ramping_enable=0, start_ramp_down=0.
- FAULT:
  - All resets asserted, ramping outputs 0, fault=1.
  - Only fault_clear -> IDLE, which clears fault and wd_expired.
  - start, stop and watchdog are ignored.
- start outside IDLE is ignored. stop in IDLE or FAULT is ignored. stop during RAMP_DOWN is ignored.
- Watchdog:
  - Active only when cfg_watchdog_en=1 and state is RAMP_UP, ADC_DELAY or RUN.
  - Any edge (either polarity) of the synchronised watchdog_in clears the counter.
  - Counter reaching WATCHDOG_TIMEOUT_CYCLES sets wd_expired=1 and goes to RAMP_DOWN (from ADC_DELAY/RUN with en=0: straight to FAULT).
  - Counter is held at 0 while inactive.
- Timeout vs. done in the same cycle: done wins.
- Counters saturate and never wrap. Width is $clog2 of the largest parameter + 1.

Optional Feature:
- Macro RESET_SEQ_RUN_COUNTER_EN.
- Defined: adds output run_cycles (32 bit). Cleared on entering RUN, increments every RUN cycle, saturates at 0xFFFFFFFF, holds its value after leaving RUN, cleared by rst.
- Undefined: port and logic absent.

Decomposition:
- Package reset_seq_pkg:
  - state enum and its 3-bit encodings;
  - default timeout constants;
  - CLK_FREQ_HZ=125000000.
- One sub-module, seq_timeout_counter: clear / enable / saturating count / terminal-count flag, parameterised by limit. Instanced for the ramp, ADC-delay and watchdog timers.

Test Plan:
- Use RAMP_TIMEOUT=100, WATCHDOG_TIMEOUT=50, ADC_DELAY=4 throughout.
- Normal run: cfg_ramp_en=2'b11, start; ramp_up_done=11 after 10 cycles -> ADC_DELAY; adc_aresetn rises exactly 4 cycles later; seq_state=3.
- Stop: stop in RUN -> adc_aresetn=0 and start_ramp_down=11 on the next edge; ramp_down_done=11 -> IDLE, dac_aresetn=0, busy=0.
- Ramp-up timeout: start with ramp_up_done held 0 -> FAULT after 100 cycles, fault=1; start ignored; fault_clear -> IDLE, fault=0.
- Watchdog expiry: cfg_watchdog_en=1, toggle watchdog_in every 30 cycles in RUN -> stays in RUN; stop toggling -> RAMP_DOWN 50 cycles after the last edge; ramp_down_done -> FAULT with wd_expired=1.
- Simultaneous/edge cases: start and stop together in IDLE -> stays IDLE. cfg_ramp_en=00 start -> RAMP_UP skipped, ADC released after 4 cycles. rst in RAMP_UP -> all outputs 0 next cycle.
